// File: rtl/sprite_motion.sv
// rtl/sprite_motion.sv - per-frame multi-sprite position/velocity stepper with wrap/bounce edges
//
// Purpose: holds position, signed velocity and per-axis edge mode for SPR_CNT
// sprites. On each accepted frame pulse it steps one sprite per clock, then
// copies every working position to the published outputs in a single cycle.
//
// Ports:
//   clk_pix, rst_pix_n     pixel clock, asynchronous active-low reset
//   frame, pause           start-of-frame pulse; pause masks frame pulses
//   cfg_we, cfg_idx        configuration write strobe and target sprite
//   cfg_x/y, cfg_vx/vy     signed position and velocity written to the sprite
//   cfg_mode               bit0 X edge mode, bit1 Y edge mode (0 wrap, 1 bounce)
//   sprx, spry             published positions, sprite i at [i*CORDW +: CORDW]
//   busy, done, overrun    pass in progress, publish pulse, sticky overrun flag

module sprite_motion #(
    parameter int CORDW     = 16,
    parameter int SPR_CNT   = 4,
    parameter int IDXW      = 2,
    parameter int VELW      = 6,
    parameter int H_RES     = 480,
    parameter int V_RES     = 272,
    parameter int SPR_DRAWW = 64,
    parameter int SPR_DRAWH = 40
) (
    input  logic                      clk_pix,
    input  logic                      rst_pix_n,
    input  logic                      frame,
    input  logic                      pause,
    input  logic                      cfg_we,
    input  logic [IDXW-1:0]           cfg_idx,
    input  logic signed [CORDW-1:0]   cfg_x,
    input  logic signed [CORDW-1:0]   cfg_y,
    input  logic signed [VELW-1:0]    cfg_vx,
    input  logic signed [VELW-1:0]    cfg_vy,
    input  logic [1:0]                cfg_mode,
    output logic [SPR_CNT*CORDW-1:0]  sprx,
    output logic [SPR_CNT*CORDW-1:0]  spry,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    // Internal index only needs to address existing sprites.
    localparam int AW = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1;
    localparam logic [AW-1:0]   LAST_IDX  = AW'(SPR_CNT - 1);
    localparam logic [IDXW:0]   SPR_CNT_W = (IDXW + 1)'(SPR_CNT);

    // Edge limits carried at CORDW+1 bits to match the unclipped step sum.
    localparam logic signed [CORDW:0] X_RES  = (CORDW + 1)'(H_RES);
    localparam logic signed [CORDW:0] Y_RES  = (CORDW + 1)'(V_RES);
    localparam logic signed [CORDW:0] X_DRAW = (CORDW + 1)'(SPR_DRAWW);
    localparam logic signed [CORDW:0] Y_DRAW = (CORDW + 1)'(SPR_DRAWH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_PUBLISH
    } state_e;

    state_e                    state_q;
    logic [AW-1:0]             idx_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      overrun_q;
    logic [SPR_CNT*CORDW-1:0]  sprx_q;
    logic [SPR_CNT*CORDW-1:0]  spry_q;

    logic signed [CORDW-1:0]   x_q  [SPR_CNT];
    logic signed [CORDW-1:0]   y_q  [SPR_CNT];
    logic signed [VELW-1:0]    vx_q [SPR_CNT];
    logic signed [VELW-1:0]    vy_q [SPR_CNT];
    logic [1:0]                mode_q [SPR_CNT];

    logic [CORDW+VELW-1:0]     step_x_d;
    logic [CORDW+VELW-1:0]     step_y_d;
    logic                      cfg_ok;
    logic [AW-1:0]             cfg_sel;

    // One axis step: returns {new position, new velocity}.
    function automatic logic [CORDW+VELW-1:0] step_axis(
        input logic signed [CORDW-1:0] p,
        input logic signed [VELW-1:0]  v,
        input logic                    bounce,
        input logic signed [CORDW:0]   res,
        input logic signed [CORDW:0]   draw
    );
        logic signed [CORDW:0]   n;
        logic signed [CORDW:0]   lim;
        logic signed [CORDW:0]   neg_draw;
        logic signed [CORDW-1:0] np;
        logic signed [VELW-1:0]  nv;
        logic signed [VELW-1:0]  v_neg;
        begin
            n        = {p[CORDW-1], p} + {{(CORDW + 1 - VELW){v[VELW-1]}}, v};
            lim      = res - draw;
            neg_draw = -draw;
            // Reflecting the most-negative velocity would overflow; clamp it.
            v_neg    = (v == {1'b1, {(VELW - 1){1'b0}}}) ? {1'b0, {(VELW - 1){1'b1}}} : -v;
            np       = n[CORDW-1:0];
            nv       = v;
            if (v == '0) begin
                np = p;
            end else if (!bounce) begin
                if (v[VELW-1] && (n <= neg_draw)) begin
                    np = res[CORDW-1:0];
                end else if (!v[VELW-1] && (n >= res)) begin
                    np = neg_draw[CORDW-1:0];
                end
            end else begin
                if (n[CORDW]) begin
                    np = '0;
                    nv = v_neg;
                end else if (n > lim) begin
                    np = lim[CORDW-1:0];
                    nv = v_neg;
                end
            end
            return {np, nv};
        end
    endfunction

    always_comb begin
        step_x_d = step_axis(x_q[idx_q], vx_q[idx_q], mode_q[idx_q][0], X_RES, X_DRAW);
        step_y_d = step_axis(y_q[idx_q], vy_q[idx_q], mode_q[idx_q][1], Y_RES, Y_DRAW);
        cfg_ok   = ({1'b0, cfg_idx} < SPR_CNT_W);
        cfg_sel  = cfg_idx[AW-1:0];
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            sprx_q    <= '0;
            spry_q    <= '0;
            for (int i = 0; i < SPR_CNT; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                vx_q[i]   <= '0;
                vy_q[i]   <= '0;
                mode_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (frame && !pause && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame && !pause) begin
                        state_q <= ST_UPDATE;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    x_q[idx_q]  <= step_x_d[CORDW+VELW-1:VELW];
                    vx_q[idx_q] <= step_x_d[VELW-1:0];
                    y_q[idx_q]  <= step_y_d[CORDW+VELW-1:VELW];
                    vy_q[idx_q] <= step_y_d[VELW-1:0];
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_PUBLISH;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_PUBLISH: begin
                    for (int i = 0; i < SPR_CNT; i++) begin
                        sprx_q[i*CORDW +: CORDW] <= x_q[i];
                        spry_q[i*CORDW +: CORDW] <= y_q[i];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Placed after the step so a same-cycle write to the sprite
            // being stepped overrides the step result.
            if (cfg_we && cfg_ok) begin
                x_q[cfg_sel]    <= cfg_x;
                y_q[cfg_sel]    <= cfg_y;
                vx_q[cfg_sel]   <= cfg_vx;
                vy_q[cfg_sel]   <= cfg_vy;
                mode_q[cfg_sel] <= cfg_mode;
            end
        end
    end

    assign sprx    = sprx_q;
    assign spry    = spry_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_motion.sv
// tb/tb_sprite_motion.sv - randomized self-checking bench for sprite_motion

module tb_sprite_motion;

    localparam int CORDW   = 16;
    localparam int SPR_CNT = 4;
    localparam int IDXW    = 3;
    localparam int VELW    = 6;
    localparam int H_RES   = 480;
    localparam int V_RES   = 272;
    localparam int DRAWW   = 64;
    localparam int DRAWH   = 40;
    localparam int VMIN    = -(1 << (VELW - 1));
    localparam int VMAX    = (1 << (VELW - 1)) - 1;

    logic                     clk_pix = 1'b0;
    logic                     rst_pix_n;
    logic                     frame;
    logic                     pause;
    logic                     cfg_we;
    logic [IDXW-1:0]          cfg_idx;
    logic [CORDW-1:0]         cfg_x;
    logic [CORDW-1:0]         cfg_y;
    logic [VELW-1:0]          cfg_vx;
    logic [VELW-1:0]          cfg_vy;
    logic [1:0]               cfg_mode;
    logic [SPR_CNT*CORDW-1:0] sprx;
    logic [SPR_CNT*CORDW-1:0] spry;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: working state and published positions.
    int wx [SPR_CNT];
    int wy [SPR_CNT];
    int wvx[SPR_CNT];
    int wvy[SPR_CNT];
    int wm [SPR_CNT];
    int px [SPR_CNT];
    int py [SPR_CNT];

    sprite_motion #(
        .CORDW(CORDW), .SPR_CNT(SPR_CNT), .IDXW(IDXW), .VELW(VELW),
        .H_RES(H_RES), .V_RES(V_RES), .SPR_DRAWW(DRAWW), .SPR_DRAWH(DRAWH)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .pause(pause),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .cfg_mode(cfg_mode),
        .sprx(sprx), .spry(spry), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int neg_sat(input int v);
        return (v == VMIN) ? VMAX : -v;
    endfunction

    function automatic void mstep(input int p, input int v, input int bounce,
                                  input int res, input int draw,
                                  output int np, output int nv);
        int n;
        n  = p + v;
        np = n;
        nv = v;
        if (v == 0) begin
            np = p;
        end else if (bounce == 0) begin
            if (v < 0 && n <= -draw) np = res;
            else if (v > 0 && n >= res) np = -draw;
        end else begin
            if (n < 0) begin
                np = 0;
                nv = neg_sat(v);
            end else if (n > res - draw) begin
                np = res - draw;
                nv = neg_sat(v);
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < SPR_CNT; i++) begin
            wx[i] = 0; wy[i] = 0; wvx[i] = 0; wvy[i] = 0; wm[i] = 0;
            px[i] = 0; py[i] = 0;
        end
    endfunction

    // skip: sprite whose step is overwritten by a same-cycle config write
    function automatic void model_frame(input int skip);
        int np, nv;
        for (int i = 0; i < SPR_CNT; i++) begin
            if (i != skip) begin
                mstep(wx[i], wvx[i], wm[i] % 2, H_RES, DRAWW, np, nv);
                wx[i] = np; wvx[i] = nv;
                mstep(wy[i], wvy[i], wm[i] / 2, V_RES, DRAWH, np, nv);
                wy[i] = np; wvy[i] = nv;
            end
            px[i] = wx[i];
            py[i] = wy[i];
        end
    endfunction

    function automatic int gx(input int i);
        return int'($signed(sprx[i*CORDW +: CORDW]));
    endfunction

    function automatic int gy(input int i);
        return int'($signed(spry[i*CORDW +: CORDW]));
    endfunction

    task automatic compare_all(input string tag);
        for (int i = 0; i < SPR_CNT; i++) begin
            check($sformatf("%s x%0d", tag, i), gx(i), px[i]);
            check($sformatf("%s y%0d", tag, i), gy(i), py[i]);
        end
    endtask

    function automatic void drive_cfg(input int idx, input int x, input int y,
                                      input int vx, input int vy, input int m);
        cfg_we   = 1'b1;
        cfg_idx  = IDXW'(idx);
        cfg_x    = CORDW'(x);
        cfg_y    = CORDW'(y);
        cfg_vx   = VELW'(vx);
        cfg_vy   = VELW'(vy);
        cfg_mode = 2'(m);
        if (idx < SPR_CNT) begin
            wx[idx] = x; wy[idx] = y; wvx[idx] = vx; wvy[idx] = vy; wm[idx] = m;
        end
    endfunction

    task automatic cfg_set(input int idx, input int x, input int y,
                           input int vx, input int vy, input int m);
        @(negedge clk_pix);
        drive_cfg(idx, x, y, vx, vy, m);
        @(negedge clk_pix);
        cfg_we = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk_pix);
            lat++;
        end
    endtask

    task automatic run_frame(input string tag);
        int lat;
        @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        wait_done(lat);
        check({tag, " latency"}, lat, SPR_CNT + 1);
        model_frame(-1);
        compare_all(tag);
        @(negedge clk_pix);
        check({tag, " done width"}, int'(done), 0);
    endtask

    initial begin
        int lat, ndone, seen;
        rst_pix_n = 1'b0;
        frame = 1'b0; pause = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_x = '0; cfg_y = '0; cfg_vx = '0; cfg_vy = '0; cfg_mode = '0;
        model_reset();
        repeat (3) @(negedge clk_pix);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset overrun", int'(overrun), 0);
        compare_all("reset");
        rst_pix_n = 1'b1;

        // Basic step
        cfg_set(0, 0, 141, -2, 0, 0);
        run_frame("basic");
        check("basic x0 const", gx(0), -2);
        check("basic y0 const", gy(0), 141);

        // Wrap sweep
        cfg_set(0, -62, 141, -2, 0, 0);
        run_frame("wrap1");
        check("wrap1 const", gx(0), 480);
        run_frame("wrap2");
        check("wrap2 const", gx(0), 478);
        cfg_set(0, 478, 141, 4, 0, 0);
        run_frame("wrap3");
        check("wrap3 const", gx(0), -64);

        // Bounce on both axes
        cfg_set(0, 414, 2, 5, -5, 3);
        run_frame("bounce1");
        check("bounce1 x const", gx(0), 416);
        check("bounce1 y const", gy(0), 0);
        run_frame("bounce2");
        check("bounce2 x const", gx(0), 411);
        check("bounce2 y const", gy(0), 5);

        // Most-negative velocity reflection
        cfg_set(0, 10, 100, -32, 0, 1);
        run_frame("vmin1");
        check("vmin1 const", gx(0), 0);
        run_frame("vmin2");
        check("vmin2 const", gx(0), 31);

        // Randomized sweeps
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < SPR_CNT; i++) begin
                cfg_set(i, int'($urandom_range(0, 700)) - 100, int'($urandom_range(0, 500)) - 100,
                        int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                        int'($urandom_range(0, 3)));
            end
            for (int f = 0; f < 3; f++) run_frame($sformatf("rand%0d_%0d", r, f));
        end
        check("overrun clean", int'(overrun), 0);

        // Config write collides with the step of sprite 1
        @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        @(negedge clk_pix);
        drive_cfg(1, 123, 77, 3, -3, 0);
        @(negedge clk_pix);
        cfg_we = 1'b0;
        wait_done(lat);
        model_frame(1);
        compare_all("collide");
        check("collide const", gx(1), 123);

        // Out-of-range index ignored
        cfg_set(4, 300, 200, 7, 7, 3);
        cfg_set(7, 301, 201, 7, 7, 3);
        run_frame("range");

        // Paused frame
        pause = 1'b1;
        @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        seen = 0;
        repeat (10) begin
            if (busy || done) seen = 1;
            @(negedge clk_pix);
        end
        pause = 1'b0;
        check("pause activity", seen, 0);
        check("pause overrun", int'(overrun), 0);
        compare_all("pause");

        // Frame while busy
        @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        ndone = 0;
        repeat (15) begin
            if (done) ndone++;
            @(negedge clk_pix);
        end
        check("overrun dones", ndone, 1);
        check("overrun flag", int'(overrun), 1);
        model_frame(-1);
        compare_all("overrun");

        // Reset in the middle of a pass (sprite 2 being stepped)
        cfg_set(2, 50, 60, 1, 1, 0);
        run_frame("prerst");
        @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        @(negedge clk_pix);
        @(negedge clk_pix);
        rst_pix_n = 1'b0;
        #1;
        model_reset();
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst overrun", int'(overrun), 0);
        compare_all("midrst");
        @(negedge clk_pix);
        rst_pix_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk_pix);
            if (done) seen = 1;
        end
        check("midrst no done", seen, 0);
        cfg_set(3, 20, 30, -4, 6, 2);
        run_frame("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_motion.md
Name: sprite_motion

Overview:
- Parametrised multi-sprite motion controller; successor to the single hard-coded "move left, wrap to right" position update in our sprite tops.
- Holds position, signed velocity and edge mode (wrap/bounce, per axis) for SPR_CNT sprites.
- Steps every sprite once per frame pulse with a sequential one-sprite-per-cycle FSM, then publishes all positions at once to the sprite instances.
- Sits between display timing (frame) and the sprite/CLUT pipeline, in the clk_pix domain.

Parameters:
- CORDW, 16, signed coordinate width (bits)
- SPR_CNT, 4, number of sprites (1–16)
- IDXW, 2, sprite index width; must be ≥ clog2(SPR_CNT)
- VELW, 6, signed velocity width (pixels/frame)
- H_RES, 480, active width (pixels)
- V_RES, 272, active height (lines)
- SPR_DRAWW, 64, scaled sprite draw width (pixels)
- SPR_DRAWH, 40, scaled sprite draw height (lines)

Ports:
- clk_pix  in  1  pixel clock
- rst_pix_n  in  1  asynchronous active-low reset
- frame  in  1  one-cycle start-of-frame pulse
- pause  in  1  high: frame pulses ignored, no overrun flagged
- cfg_we  in  1  config write strobe
- cfg_idx  in  IDXW  sprite to configure
- cfg_x, cfg_y  in  CORDW  signed position
- cfg_vx, cfg_vy  in  VELW  signed velocity
- cfg_mode  in  2  bit0 X edge mode, bit1 Y edge mode (0 = wrap, 1 = bounce)
- sprx, spry  out  SPR_CNT*CORDW  published positions; sprite i at [i*CORDW +: CORDW]
- busy  out  1  update in progress
- done  out  1  one-cycle pulse when new positions are published
- overrun  out  1  sticky: frame arrived while busy

Behaviour:
- Reset (async assert, sync release): all working and published positions = 0, velocities = 0, modes = 0; busy = 0, done = 0, overrun = 0; FSM in IDLE.
- FSM states:
  - IDLE: frame && !pause → UPDATE with idx = 0.
  - UPDATE: process sprite idx; idx == SPR_CNT-1 → PUBLISH, else idx + 1.
  - PUBLISH: copy all working positions to sprx/spry, done = 1 → IDLE.
- Timing: busy = 1 in UPDATE and PUBLISH. Latency from frame to done is SPR_CNT + 1 cycles; outputs change only in PUBLISH.
- Per-sprite arithmetic:
  - nx = x + sext(vx), computed at CORDW+1 bits (no overflow); y axis identical using V_RES/SPR_DRAWH.
  - Wrap, vx < 0, nx ≤ -SPR_DRAWW: x = H_RES.
  - Wrap, vx > 0, nx ≥ H_RES: x = -SPR_DRAWW.
  - Wrap, otherwise: x = nx.
  - Bounce, nx < 0: x = 0, vx = -vx.
  - Bounce, nx > H_RES-SPR_DRAWW: x = H_RES-SPR_DRAWW, vx = -vx.
  - Bounce, otherwise: x = nx.
  - Negating the most-negative velocity saturates to the most-positive value.
  - vx = 0: position unchanged in either mode.
- Configuration:
  - cfg_we writes working x, y, vx, vy and mode of cfg_idx in one cycle, in any state.
  - Writes appear on sprx/spry only at the next PUBLISH.
  - Same cycle as UPDATE of the same index: cfg write wins; the step result is discarded.
  - cfg_idx ≥ SPR_CNT: write ignored.
- Frame handling:
  - frame while busy (and !pause): ignored, overrun set (sticky until reset).
  - frame && pause: ignored, no overrun.
  - pause rising during UPDATE: the current pass completes.
- Reset mid-operation: immediate return to reset values; no done pulse.

Test Plan:
- Reset, then cfg sprite 0 to x = 0, y = 141, vx = -2, mode 0; one frame → done exactly 5 cycles later (SPR_CNT = 4); sprx[0] = -2, spry[0] = 141; other sprites at 0.
- Wrap sweep: x = -62, vx = -2, two frames → x = H_RES = 480, then 478; x = 478, vx = +4 → nx = 482 ≥ 480, so x = -64.
- Bounce X: x = 414, vx = +5 → x = 416 (= 480-64), vx = -5; next frame → x = 411. Bounce Y: y = 2, vy = -5 → y = 0, vy = +5.
- frame pulses 2 cycles apart → second ignored, overrun = 1, exactly one done; with pause = 1, frame → no busy, no done, overrun unchanged.
- Collision and range: cfg write to idx 1 in the same cycle UPDATE processes idx 1 → published value equals the cfg value; cfg_idx = 4 with SPR_CNT = 4 → no state change. vx = -32 (VELW = 6) bouncing at x = 10 → x = 0, vx = +31.
- Assert rst_pix_n low mid-UPDATE (idx = 2) → outputs 0 immediately and asynchronously, busy = 0, no done; after release, normal operation on the next frame.
